frame_1010_tx: RTL and testbench

- Serial frame transmitter; the sending end of the team's overlapping "1010" sequence-detector link.
- Accepts a DATA_W-bit word over a valid/ready handshake and emits preamble 1010, then the payload MSB-first, then a forced idle gap of zeros.
- Payload is bit-stuffed so that an overlapping 1010 detector on the line fires exactly once per frame: on the last preamble bit.

---
 rtl/link1010_pkg.sv | 20 ++
 rtl/stuff_tracker.sv | 26 ++
 rtl/frame_1010_tx.sv | 149 ++++++++++++++
 tb/tb_frame_1010_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/link1010_pkg.sv
// Shared definitions for the 1010 link: transmitter state encoding,
// preamble pattern and the history pattern that forces a stuff bit.
package link1010_pkg;

  typedef enum logic [2:0] {
    GAP,
    IDLE,
    PREAMBLE,
    PAYLOAD,
    TAIL
  } tx_state_t;

  localparam int PREAMBLE_LEN = 4;
  localparam logic [PREAMBLE_LEN-1:0] PREAMBLE_PAT = 4'b1010;
  localparam int PRE_CNT_W = $clog2(PREAMBLE_LEN + 1);

  // Last three line bits equal to this mean the next bit must be a 1.
  localparam logic [2:0] STUFF_TRIGGER = 3'b101;

endpackage

// File: rtl/stuff_tracker.sv
// Three-bit line history (newest bit at position 0). need_stuff flags that
// the next line bit must be a forced 1. Also reused by the receiver destuffer.
module stuff_tracker
  import link1010_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift_en,
  input  logic line_bit,
  output logic need_stuff
);

  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= {hist[1:0], line_bit};
    end
  end

  assign need_stuff = (hist == STUFF_TRIGGER);

endmodule

// File: rtl/frame_1010_tx.sv
// Serial frame transmitter: preamble 1010, bit-stuffed MSB-first payload,
// then a forced zero gap. All outputs are registered.
module frame_1010_tx
  import link1010_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MIN_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              stuffed,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(MIN_GAP + 1);

  tx_state_t              state;
  tx_state_t              nxt_state;
  logic [GAP_W-1:0]       gap_cnt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [PRE_CNT_W-1:0]   pre_cnt;
  logic [PREAMBLE_LEN-1:0] pre_sr;
  logic [DATA_W-1:0]      shreg;

  logic emit;
  logic emit_bit;
  logic emit_stuff;
  logic data_take;
  logic payload_step;
  logic need_stuff;

  // History follows exactly the bits put on the line; it is held clear
  // whenever the next cycle carries no frame bit.
  stuff_tracker u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (!emit),
    .shift_en   (emit),
    .line_bit   (emit_bit),
    .need_stuff (need_stuff)
  );

  // Decide the bit for the next cycle; outputs are registered from this.
  always_comb begin
    nxt_state    = state;
    emit         = 1'b0;
    emit_bit     = 1'b0;
    emit_stuff   = 1'b0;
    data_take    = 1'b0;
    payload_step = 1'b0;
    case (state)
      GAP: begin
        if (gap_cnt == GAP_W'(MIN_GAP - 1)) nxt_state = IDLE;
      end
      IDLE: begin
        if (in_valid) begin
          nxt_state = PREAMBLE;
          emit      = 1'b1;
          emit_bit  = PREAMBLE_PAT[PREAMBLE_LEN-1];
        end
      end
      PREAMBLE: begin
        if (pre_cnt != PRE_CNT_W'(PREAMBLE_LEN)) begin
          emit     = 1'b1;
          emit_bit = pre_sr[PREAMBLE_LEN-1];
        end else begin
          payload_step = 1'b1;
        end
      end
      PAYLOAD: begin
        if (bit_cnt != CNT_W'(DATA_W)) begin
          payload_step = 1'b1;
        end else if (need_stuff) begin
          nxt_state  = TAIL;
          emit       = 1'b1;
          emit_bit   = 1'b1;
          emit_stuff = 1'b1;
        end else begin
          nxt_state = GAP;
        end
      end
      TAIL: begin
        nxt_state = GAP;
      end
      default: begin
        nxt_state = GAP;
      end
    endcase

    if (payload_step) begin
      nxt_state = PAYLOAD;
      emit      = 1'b1;
      if (need_stuff) begin
        emit_bit   = 1'b1;
        emit_stuff = 1'b1;
      end else begin
        emit_bit  = shreg[DATA_W-1];
        data_take = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= GAP;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      pre_cnt    <= '0;
      pre_sr     <= '0;
      shreg      <= '0;
      tx_bit     <= 1'b0;
      tx_active  <= 1'b0;
      stuffed    <= 1'b0;
      in_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      tx_bit     <= emit_bit;
      tx_active  <= emit;
      stuffed    <= emit_stuff;
      in_ready   <= (nxt_state == IDLE);
      frame_done <= ((state == PAYLOAD) || (state == TAIL)) && (nxt_state == GAP);
      gap_cnt    <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      // The first preamble bit leaves with the handshake; pre_sr holds the rest.
      if (state == IDLE && in_valid) begin
        shreg   <= in_data;
        bit_cnt <= '0;
        pre_cnt <= PRE_CNT_W'(1);
        pre_sr  <= PREAMBLE_PAT << 1;
      end else if (state == PREAMBLE && pre_cnt != PRE_CNT_W'(PREAMBLE_LEN)) begin
        pre_cnt <= pre_cnt + PRE_CNT_W'(1);
        pre_sr  <= pre_sr << 1;
      end

      if (data_take) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_1010_tx.sv
// Scoreboard bench for frame_1010_tx: stimulus pushes expected line bits from
// a line-history model; a negedge monitor pops, detects 1010 and destuffs.
module tb_frame_1010_tx;

  localparam int DATA_W  = 8;
  localparam int MIN_GAP = 2;
  localparam int N_RAND  = 2000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_active;
  logic              stuffed;
  logic              frame_done;

  frame_1010_tx #(.DATA_W(DATA_W), .MIN_GAP(MIN_GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_bit     (tx_bit),
    .tx_active  (tx_active),
    .stuffed    (stuffed),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { bit b; bit s; } exp_bit_t;
  typedef struct { logic [DATA_W-1:0] w; int len; } exp_frame_t;

  exp_bit_t   exp_bits[$];
  exp_frame_t exp_frames[$];

  int checks = 0;
  int failures = 0;
  int frames_sent = 0;
  int frames_seen = 0;
  int det_hits = 0;
  int aborted = 0;
  int last_gap = 0;

  task automatic check_output(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected frame from the rule: whenever the last three line bits are 101
  // the next bit is a forced 1, including once more after the final data bit.
  task automatic push_frame(logic [DATA_W-1:0] w);
    bit line[$];
    exp_bit_t e;
    exp_frame_t f;
    int i;
    int n;
    bit trig;
    for (int k = 0; k < 4; k++) begin
      e.b = (k % 2 == 0);
      e.s = 1'b0;
      line.push_back(e.b);
      exp_bits.push_back(e);
    end
    i = DATA_W - 1;
    forever begin
      n = line.size();
      trig = (line[n-3] == 1'b1) && (line[n-2] == 1'b0) && (line[n-1] == 1'b1);
      if (trig) begin
        e.b = 1'b1;
        e.s = 1'b1;
      end else if (i < 0) begin
        break;
      end else begin
        e.b = w[i];
        e.s = 1'b0;
        i--;
      end
      line.push_back(e.b);
      exp_bits.push_back(e);
    end
    f.w = w;
    f.len = line.size();
    exp_frames.push_back(f);
    frames_sent++;
  endtask

  // Wait for in_ready, then hand over w; hold keeps in_valid high afterwards
  // with garbage data while the block is busy.
  task automatic apply_stimulus(logic [DATA_W-1:0] w, bit hold);
    int t = 0;
    while (!in_ready && t < 200) begin
      in_valid = hold;
      in_data  = DATA_W'($urandom);
      @(posedge clk); #2;
      t++;
    end
    if (t >= 200) begin
      check_output("ready_timeout", 0, 1);
    end else begin
      in_valid = 1'b1;
      in_data  = w;
      push_frame(w);
      @(posedge clk); #2;
      in_valid = hold;
      in_data  = DATA_W'($urandom);
    end
  endtask

  task automatic idle_cycles(int n);
    for (int k = 0; k < n; k++) begin
      in_data  = DATA_W'($urandom);
      in_valid = in_ready ? 1'b0 : 1'($urandom);
      @(posedge clk); #2;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_frames.size() != 0 || tx_active) && t < 1000) begin
      in_valid = 1'b0;
      @(posedge clk); #2;
      t++;
    end
    if (t >= 1000) check_output("drain_timeout", 0, 1);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
  endtask

  // Monitor state.
  bit                rst_edge = 1'b1;
  bit                prev_active = 1'b0;
  int                pos = 0;
  int                idle_n = 0;
  int                gap_run = 0;
  logic [3:0]        det = '0;
  bit                fl[$];
  logic [DATA_W-1:0] rec = '0;
  int                nrec = 0;

  always @(posedge clk) rst_edge = reset;

  always @(negedge clk) begin
    exp_bit_t   e;
    exp_frame_t f;
    bit         hit;
    int         n;
    det = {det[2:0], tx_bit};
    hit = (det == 4'b1010);
    if (rst_edge) begin
      check_output("rst_tx_bit", int'(tx_bit), 0);
      check_output("rst_tx_active", int'(tx_active), 0);
      check_output("rst_stuffed", int'(stuffed), 0);
      check_output("rst_frame_done", int'(frame_done), 0);
      check_output("rst_in_ready", int'(in_ready), 0);
      exp_bits.delete();
      exp_frames.delete();
      fl.delete();
      pos = 0;
      rec = '0;
      nrec = 0;
      idle_n = 1;
      gap_run = 1;
      prev_active = 1'b0;
    end else begin
      check_output("frame_done", int'(frame_done), int'(prev_active && !tx_active));
      if (tx_active) begin
        if (pos == 0) begin
          last_gap = gap_run;
          if (gap_run < MIN_GAP + 1) check_output("frame_spacing", gap_run, MIN_GAP + 1);
        end
        if (exp_bits.size() == 0) begin
          check_output("unexpected_bit", 1, 0);
        end else begin
          e = exp_bits.pop_front();
          check_output("tx_bit", int'(tx_bit), int'(e.b));
          check_output("stuffed", int'(stuffed), int'(e.s));
        end
        check_output("detector_hit", int'(hit), int'(pos == 3));
        if (hit) det_hits++;
        if (pos >= 4) begin
          n = fl.size();
          if (!(fl[n-3] == 1'b1 && fl[n-2] == 1'b0 && fl[n-1] == 1'b1)) begin
            rec = {rec[DATA_W-2:0], tx_bit};
            nrec++;
          end
        end
        fl.push_back(tx_bit);
        pos++;
        gap_run = 0;
        idle_n = 0;
        check_output("busy_in_ready", int'(in_ready), 0);
      end else begin
        if (tx_bit !== 1'b0) check_output("idle_tx_bit", int'(tx_bit), 0);
        if (stuffed !== 1'b0) check_output("idle_stuffed", int'(stuffed), 0);
        if (hit) check_output("stray_detector_hit", 1, 0);
        if (prev_active) begin
          if (exp_frames.size() == 0) begin
            check_output("unexpected_frame", 1, 0);
          end else begin
            f = exp_frames.pop_front();
            check_output("recovered_data", int'(rec), int'(f.w));
            check_output("data_bits", nrec, DATA_W);
            check_output("frame_len", pos, f.len);
          end
          frames_seen++;
          fl.delete();
          pos = 0;
          rec = '0;
          nrec = 0;
        end
        idle_n++;
        gap_run++;
        check_output("in_ready", int'(in_ready), int'(idle_n > MIN_GAP));
      end
      prev_active = tx_active;
    end
  end

  initial begin
    $display("[TB] start");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // Back-to-back with valid held: 00, A5, FF, random.
    apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'hA5, 1'b1);
    @(negedge clk); #1;
    check_output("b2b_gap_a5", last_gap, MIN_GAP + 1);
    apply_stimulus(8'hFF, 1'b1);
    @(negedge clk); #1;
    check_output("b2b_gap_ff", last_gap, MIN_GAP + 1);
    apply_stimulus(DATA_W'($urandom), 1'b1);
    @(negedge clk); #1;
    check_output("b2b_gap_rand", last_gap, MIN_GAP + 1);
    in_valid = 1'b0;
    drain();

    // Reset after three data bits of an all-zero payload.
    apply_stimulus(8'h00, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    aborted++;
    @(posedge clk); #2;
    reset = 1'b0;
    apply_stimulus(8'hC3, 1'b0);
    drain();

    for (int k = 0; k < N_RAND; k++) begin
      apply_stimulus(DATA_W'($urandom), 1'($urandom));
      if ($urandom_range(3, 0) == 0) idle_cycles($urandom_range(5, 0));
    end
    drain();

    check_output("frames_seen", frames_seen, frames_sent - aborted);
    check_output("detector_hits", det_hits, frames_seen + aborted);
    check_output("queue_empty", exp_bits.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
